// File: rtl/mda_char_overlay.sv
// MDA character overlay: captures ISA POST codes and shows them as hex digits
// over a fixed run of text cells. Until the first VRAM write it also shows a
// blank fill, and it generates the cursor and character blink phases.
module mda_char_overlay #(
   parameter int          OVL_BYTES    = 1,
   parameter logic [13:0] OVL_POS      = 14'd78,
   parameter logic [19:0] POST_PORT    = 20'h00080,
   parameter logic [7:0]  BLANK_CHAR   = 8'h20,
   parameter logic [7:0]  BLANK_ATTR   = 8'h18,
   parameter logic [7:0]  OVL_ATTR     = 8'h70,
   parameter int          BLINK_FRAMES = 16,
   parameter int          HIDE_FRAMES  = 0
) (
   input  logic        clk,
   input  logic        rst_l,
   input  logic [19:0] bus_a,
   input  logic        bus_aen,
   input  logic        bus_iow_l,
   input  logic        bus_memw_l,
   input  logic [7:0]  bus_d,
   input  logic        vram_cs,
   input  logic        vsync,
   input  logic [13:0] crtc_addr,
   input  logic        vram_read_char,
   input  logic        vram_read_att,
   input  logic [7:0]  vram_data,
   output logic [7:0]  char_data,
   output logic        blink_cursor,
   output logic        blink_char,
   output logic        post_code_present
);

   localparam int HW   = OVL_BYTES * 8;
   localparam int NDIG = 2 * OVL_BYTES;
   localparam int BW   = $clog2(BLINK_FRAMES);
   localparam int TW   = (HIDE_FRAMES > 0) ? $clog2(HIDE_FRAMES + 1) : 1;

   logic          iow_q, iow_d, memw_q, memw_d, vsync_q, vsync_d;
   logic [HW-1:0] hist_q, hist_d;
   logic          present_q, present_d, vram_wr_q, vram_wr_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          bcur_q, bcur_d, bchr_q, bchr_d;
   logic [TW-1:0] hide_q, hide_d;

   logic          iow_ev, memw_ev, tick, post_wr, visible, in_ovl;
   logic [13:0]   off;
   logic [2:0]    dig;
   logic [3:0]    nib;
   logic [7:0]    hex;

   // Event detection and next-state for history, flags, blink and hide timer
   always_comb begin
      iow_ev    = iow_q & ~bus_iow_l;
      memw_ev   = memw_q & ~bus_memw_l;
      tick      = vsync & ~vsync_q;
      post_wr   = iow_ev & ~bus_aen & (bus_a == POST_PORT);

      iow_d     = bus_iow_l;
      memw_d    = bus_memw_l;
      vsync_d   = vsync;
      hist_d    = hist_q;
      present_d = present_q;
      vram_wr_d = vram_wr_q;
      bcnt_d    = bcnt_q;
      bcur_d    = bcur_q;
      bchr_d    = bchr_q;
      hide_d    = hide_q;

      // newest byte enters at the LSB, oldest falls off the MSB
      if (post_wr) begin
         hist_d    = HW'({hist_q, bus_d});
         present_d = 1'b1;
      end
      if (memw_ev && vram_cs) vram_wr_d = 1'b1;

      // character phase flips on each cursor 1->0 transition
      if (tick) begin
         if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
            bcnt_d = '0;
            bcur_d = ~bcur_q;
            if (bcur_q) bchr_d = ~bchr_q;
         end else begin
            bcnt_d = bcnt_q + 1'b1;
         end
      end

      // a POST capture restarts the timer even when a frame tick lands too
      if (HIDE_FRAMES != 0) begin
         if (post_wr)
            hide_d = '0;
         else if (tick && hide_q != TW'(HIDE_FRAMES))
            hide_d = hide_q + 1'b1;
      end
   end

   // State registers; strobe edge regs idle high so reset never fakes an event
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         iow_q     <= 1'b1;
         memw_q    <= 1'b1;
         vsync_q   <= 1'b0;
         hist_q    <= '0;
         present_q <= 1'b0;
         vram_wr_q <= 1'b0;
         bcnt_q    <= '0;
         bcur_q    <= 1'b0;
         bchr_q    <= 1'b0;
         hide_q    <= '0;
      end else begin
         iow_q     <= iow_d;
         memw_q    <= memw_d;
         vsync_q   <= vsync_d;
         hist_q    <= hist_d;
         present_q <= present_d;
         vram_wr_q <= vram_wr_d;
         bcnt_q    <= bcnt_d;
         bcur_q    <= bcur_d;
         bchr_q    <= bchr_d;
         hide_q    <= hide_d;
      end
   end

   // Zero-latency pixel byte select: overlay, then blank fill, then VRAM
   always_comb begin
      visible = present_q && ((HIDE_FRAMES == 0) || (hide_q < TW'(HIDE_FRAMES)));
      off     = crtc_addr - OVL_POS;
      in_ovl  = (crtc_addr >= OVL_POS) && (off < 14'(NDIG));
      dig     = off[2:0];
      // digit 0 is the top nibble of the oldest byte
      nib     = 4'(hist_q >> {3'(NDIG - 1) - dig, 2'b00});
      hex     = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});

      char_data = vram_data;
      if (visible && in_ovl && vram_read_char)
         char_data = hex;
      else if (visible && in_ovl && vram_read_att)
         char_data = OVL_ATTR;
      else if (!vram_wr_q && vram_read_char)
         char_data = BLANK_CHAR;
      else if (!vram_wr_q && vram_read_att)
         char_data = BLANK_ATTR;
   end

   assign blink_cursor      = bcur_q;
   assign blink_char        = bchr_q;
   assign post_code_present = present_q;

endmodule

// File: tb/tb_mda_char_overlay.sv
// Directed bench for mda_char_overlay. Two instances share the stimulus:
// u1 uses defaults (1 byte, no hide), u2 keeps 2 bytes, blinks every 2
// frames and hides after 3 frames.
module tb_mda_char_overlay;

   logic        clk = 1'b0;
   logic        rst_l;
   logic [19:0] bus_a;
   logic        bus_aen, bus_iow_l, bus_memw_l;
   logic [7:0]  bus_d;
   logic        vram_cs, vsync;
   logic [13:0] crtc_addr;
   logic        vram_read_char, vram_read_att;
   logic [7:0]  vram_data;
   logic [7:0]  cd1, cd2;
   logic        bc1, bch1, pp1, bc2, bch2, pp2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mda_char_overlay u1 (
      .clk(clk), .rst_l(rst_l), .bus_a(bus_a), .bus_aen(bus_aen),
      .bus_iow_l(bus_iow_l), .bus_memw_l(bus_memw_l), .bus_d(bus_d),
      .vram_cs(vram_cs), .vsync(vsync), .crtc_addr(crtc_addr),
      .vram_read_char(vram_read_char), .vram_read_att(vram_read_att),
      .vram_data(vram_data), .char_data(cd1), .blink_cursor(bc1),
      .blink_char(bch1), .post_code_present(pp1));

   mda_char_overlay #(.OVL_BYTES(2), .BLINK_FRAMES(2), .HIDE_FRAMES(3)) u2 (
      .clk(clk), .rst_l(rst_l), .bus_a(bus_a), .bus_aen(bus_aen),
      .bus_iow_l(bus_iow_l), .bus_memw_l(bus_memw_l), .bus_d(bus_d),
      .vram_cs(vram_cs), .vsync(vsync), .crtc_addr(crtc_addr),
      .vram_read_char(vram_read_char), .vram_read_att(vram_read_att),
      .vram_data(vram_data), .char_data(cd2), .blink_cursor(bc2),
      .blink_char(bch2), .post_code_present(pp2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clk1();
      @(posedge clk);
      #1;
   endtask

   // set up a fetch and let the combinational output settle
   task automatic rd(input logic [13:0] a, input logic c, input logic t, input logic [7:0] vd);
      crtc_addr = a; vram_read_char = c; vram_read_att = t; vram_data = vd;
      #1;
   endtask

   task automatic iow(input logic [19:0] a, input logic aen, input logic [7:0] d, input int hold);
      bus_a = a; bus_aen = aen; bus_d = d; bus_iow_l = 1'b0;
      repeat (hold) clk1();
      bus_iow_l = 1'b1; bus_aen = 1'b0;
      clk1();
   endtask

   task automatic memw(input logic cs);
      vram_cs = cs; bus_memw_l = 1'b0;
      clk1();
      bus_memw_l = 1'b1; vram_cs = 1'b0;
      clk1();
   endtask

   task automatic vs_pulse();
      vsync = 1'b1; clk1();
      vsync = 1'b0; clk1();
   endtask

   // check u2's four digits at 78..81 against a string of hex characters
   task automatic chk4(input string tag, input logic [31:0] exp);
      for (int k = 0; k < 4; k++) begin
         rd(14'd78 + 14'(k), 1'b1, 1'b0, 8'hEE);
         chk($sformatf("%s[%0d]", tag, k), {24'h0, cd2}, {24'h0, exp[31-8*k -: 8]});
      end
   endtask

   initial begin
      int ct, cc;
      logic pc, pch;
      rst_l = 1'b0; bus_a = '0; bus_aen = 1'b0; bus_iow_l = 1'b1; bus_memw_l = 1'b1;
      bus_d = '0; vram_cs = 1'b0; vsync = 1'b0;
      crtc_addr = '0; vram_read_char = 1'b0; vram_read_att = 1'b0; vram_data = '0;
      repeat (3) clk1();

      // reset state
      rd(14'd0, 1'b1, 1'b0, 8'h55);
      chk("rst_blank_char", {24'h0, cd1}, 32'h20);
      rd(14'd0, 1'b0, 1'b1, 8'h55);
      chk("rst_blank_att", {24'h0, cd1}, 32'h18);
      chk("rst_flags", {28'h0, bc1, bch1, pp1, pp2}, 32'h0);
      rst_l = 1'b1;
      repeat (2) clk1();

      // blank fill persists until a VRAM-window write
      memw(1'b0);
      rd(14'd0, 1'b1, 1'b0, 8'h41);
      chk("memw_no_cs", {24'h0, cd1}, 32'h20);
      rd(14'd78, 1'b1, 1'b0, 8'h41);
      chk("blank_no_post", {24'h0, cd1}, 32'h20);
      memw(1'b1);
      rd(14'd0, 1'b1, 1'b0, 8'h41);
      chk("memw_pass", {24'h0, cd1}, 32'h41);
      rd(14'd0, 1'b0, 1'b1, 8'h07);
      chk("memw_pass_att", {24'h0, cd1}, 32'h07);

      // POST history
      iow(20'h00080, 1'b0, 8'h12, 1);
      chk("present", {30'h0, pp1, pp2}, 32'h3);
      chk4("h0012", "0012");
      iow(20'h00080, 1'b0, 8'hAB, 1);
      chk4("h12AB", "12AB");
      iow(20'h00080, 1'b0, 8'h05, 1);
      chk4("hAB05", "AB05");
      iow(20'h00080, 1'b0, 8'h3C, 10);
      chk4("hold10", "053C");
      rd(14'd78, 1'b1, 1'b0, 8'hEE);
      chk("u1_d0", {24'h0, cd1}, 32'h33);
      rd(14'd79, 1'b1, 1'b0, 8'hEE);
      chk("u1_d1", {24'h0, cd1}, 32'h43);
      rd(14'd78, 1'b0, 1'b1, 8'hEE);
      chk("u1_att", {24'h0, cd1}, 32'h70);
      rd(14'd80, 1'b1, 1'b0, 8'h5A);
      chk("u1_past_end", {24'h0, cd1}, 32'h5A);
      rd(14'd77, 1'b1, 1'b0, 8'h5B);
      chk("before_start", {16'h0, cd1, cd2}, 32'h5B5B);
      rd(14'd78, 1'b0, 1'b0, 8'h5C);
      chk("no_qual", {16'h0, cd1, cd2}, 32'h5C5C);
      iow(20'h00080, 1'b1, 8'h77, 1);
      chk4("aen_blk", "053C");
      iow(20'h00081, 1'b0, 8'h66, 1);
      chk4("port81", "053C");

      // hide timer: three frames hide u2, u1 never hides
      repeat (3) vs_pulse();
      rd(14'd78, 1'b1, 1'b0, 8'h99);
      chk("hidden", {16'h0, cd1, cd2}, 32'h3399);
      rd(14'd79, 1'b0, 1'b1, 8'h98);
      chk("hidden_att", {24'h0, cd2}, 32'h98);
      // capture and tick in the same cycle: capture wins
      bus_a = 20'h00080; bus_d = 8'h5A; bus_iow_l = 1'b0; vsync = 1'b1;
      clk1();
      bus_iow_l = 1'b1; vsync = 1'b0;
      clk1();
      chk4("coinc", "3C5A");
      repeat (2) vs_pulse();
      rd(14'd81, 1'b1, 1'b0, 8'h99);
      chk("timer_2", {24'h0, cd2}, 32'h41);
      vs_pulse();
      rd(14'd81, 1'b1, 1'b0, 8'h99);
      chk("timer_3", {24'h0, cd2}, 32'h99);

      // asynchronous reset mid-operation
      #2 rst_l = 1'b0;
      #1;
      rd(14'd78, 1'b1, 1'b0, 8'h99);
      chk("midrst", {15'h0, pp1, pp2, cd1, cd2}, 32'h2020);
      clk1();
      rst_l = 1'b1;
      repeat (2) clk1();

      // blink: 8 frames on u2 -> cursor 4 toggles, char 2 toggles
      ct = 0; cc = 0; pc = bc2; pch = bch2;
      for (int i = 0; i < 8; i++) begin
         vs_pulse();
         if (bc2 !== pc) ct++;
         if (bch2 !== pch) cc++;
         pc = bc2; pch = bch2;
      end
      chk("cur_toggles", ct, 4);
      chk("chr_toggles", cc, 2);
      chk("blink_end", {28'h0, bc1, bch1, bc2, bch2}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
